window_spill_fill_ctrl: RTL and testbench

//  Register-window manager for the SPARC integer register file.
//  - Accepts SAVE/RESTORE requests from decode and owns the WIM.
//  - Window available: pulses the register file's cwp_dec/cwp_inc.
//  - Window overflow: spills 16 words (r16..r31) of the invalid window to memory, then rotates WIM.
//  - Window underflow: fills the same 16 registers from memory, then rotates WIM.
//  - Sits between decode, the register file's window-indexed side port and the data-memory port.

---
 rtl/window_spill_fill_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_window_spill_fill_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_spill_fill_ctrl.sv
// SPARC register-window manager: owns the WIM, answers SAVE/RESTORE from decode,
// and spills/fills r16..r31 of the invalid window through the memory port on traps.
module window_spill_fill_ctrl #(
  parameter int NWINDOWS = 8,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                save_req,
  input  logic                restore_req,
  input  logic [ADDR_W-1:0]   sp_base,
  input  logic [4:0]          cwp,
  output logic                busy,
  output logic                done,
  output logic                req_err,
  output logic                cwp_dec,
  output logic                cwp_inc,
  output logic [NWINDOWS-1:0] wim_out,
  output logic [4:0]          rf_win,
  output logic [3:0]          rf_idx,
  output logic                rf_rd_en,
  input  logic [31:0]         rf_rd_data,
  output logic                rf_wr_en,
  output logic [31:0]         rf_wr_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic [CNT_W-1:0]    spill_cnt,
  output logic [CNT_W-1:0]    fill_cnt
);

  localparam int                WIN_W   = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
  localparam logic [NWINDOWS-1:0] WIM_RST = NWINDOWS'(1) << (2 % NWINDOWS);

  typedef enum logic [2:0] {
    IDLE, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WAIT, FILL_WR, COMMIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_k;
  logic [4:0]          r_win;
  logic [ADDR_W-1:0]   r_base;
  logic [NWINDOWS-1:0] r_wim;
  logic                r_spill;
  logic                r_rd_vld;
  logic [31:0]         r_wdata;
  logic [31:0]         r_fill_data;
  logic                r_done_q, r_dec_q, r_inc_q, r_err_q;
  logic [CNT_W-1:0]    r_spill_cnt, r_fill_cnt;

  logic [4:0] w_ns, w_nr;
  logic       w_idle, w_trap_ns, w_trap_nr;
  logic       w_save_only, w_rest_only;

  assign w_ns        = (cwp == 5'd0) ? 5'(NWINDOWS - 1) : cwp - 5'd1;
  assign w_nr        = (cwp == 5'(NWINDOWS - 1)) ? 5'd0 : cwp + 5'd1;
  assign w_trap_ns   = r_wim[w_ns[WIN_W-1:0]];
  assign w_trap_nr   = r_wim[w_nr[WIN_W-1:0]];
  assign w_idle      = (r_state == IDLE);
  assign w_save_only = w_idle & save_req & ~restore_req;
  assign w_rest_only = w_idle & restore_req & ~save_req;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_save_only && w_trap_ns)      w_state_nxt = SPILL_RD;
        else if (w_rest_only && w_trap_nr) w_state_nxt = FILL_REQ;
      end
      SPILL_RD:  w_state_nxt = SPILL_WR;
      SPILL_WR:  if (mem_ready) w_state_nxt = (r_k == 4'd15) ? COMMIT : SPILL_RD;
      FILL_REQ:  if (mem_ready) w_state_nxt = FILL_WAIT;
      FILL_WAIT: if (mem_rvalid) w_state_nxt = FILL_WR;
      FILL_WR:   w_state_nxt = (r_k == 4'd15) ? COMMIT : FILL_REQ;
      COMMIT:    w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // No-trap replies are registered so they land one cycle after the request,
  // while COMMIT drives its own pulses directly.
  always_comb begin
    busy     = ~w_idle;
    rf_rd_en = 1'b0;
    rf_wr_en = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    done     = r_done_q;
    cwp_dec  = r_dec_q;
    cwp_inc  = r_inc_q;
    req_err  = r_err_q;
    unique case (r_state)
      SPILL_RD: rf_rd_en = 1'b1;
      SPILL_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      FILL_REQ: mem_req  = 1'b1;
      FILL_WR:  rf_wr_en = 1'b1;
      COMMIT: begin
        done    = 1'b1;
        cwp_dec = r_spill;
        cwp_inc = ~r_spill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_k         <= '0;
      r_win       <= '0;
      r_base      <= '0;
      r_wim       <= WIM_RST;
      r_spill     <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_wdata     <= '0;
      r_fill_data <= '0;
      r_done_q    <= 1'b0;
      r_dec_q     <= 1'b0;
      r_inc_q     <= 1'b0;
      r_err_q     <= 1'b0;
      r_spill_cnt <= '0;
      r_fill_cnt  <= '0;
    end else begin
      r_dec_q  <= w_save_only & ~w_trap_ns;
      r_inc_q  <= w_rest_only & ~w_trap_nr;
      r_done_q <= (w_save_only & ~w_trap_ns) | (w_rest_only & ~w_trap_nr);
      r_err_q  <= w_idle & save_req & restore_req;
      r_rd_vld <= (r_state == SPILL_RD);
      // Side-port data is only valid the cycle after the read; hold it for stalls.
      if (r_rd_vld) r_wdata <= rf_rd_data;
      unique case (r_state)
        IDLE: begin
          if (w_save_only && w_trap_ns) begin
            r_win   <= w_ns;
            r_base  <= sp_base;
            r_spill <= 1'b1;
          end else if (w_rest_only && w_trap_nr) begin
            r_win   <= w_nr;
            r_base  <= sp_base;
            r_spill <= 1'b0;
          end
        end
        SPILL_WR:  if (mem_ready && r_k != 4'd15) r_k <= r_k + 4'd1;
        FILL_WAIT: if (mem_rvalid) r_fill_data <= mem_rdata;
        FILL_WR:   if (r_k != 4'd15) r_k <= r_k + 4'd1;
        COMMIT: begin
          r_k <= '0;
          if (r_spill) begin
            r_wim <= {r_wim[0], r_wim[NWINDOWS-1:1]};
            if (r_spill_cnt != '1) r_spill_cnt <= r_spill_cnt + CNT_W'(1);
          end else begin
            r_wim <= {r_wim[NWINDOWS-2:0], r_wim[NWINDOWS-1]};
            if (r_fill_cnt != '1) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wim_out    = r_wim;
  assign rf_win     = r_win;
  assign rf_idx     = r_k;
  assign rf_wr_data = r_fill_data;
  assign mem_addr   = r_base + (ADDR_W'(r_k) << 2);
  assign mem_wdata  = r_rd_vld ? rf_rd_data : r_wdata;
  assign spill_cnt  = r_spill_cnt;
  assign fill_cnt   = r_fill_cnt;

endmodule

// File: tb/tb_window_spill_fill_ctrl.sv
// Directed bench for window_spill_fill_ctrl with register-file and memory models;
// expected stores/loads are queued at stimulus time and checked as the DUT issues them.
module tb_window_spill_fill_ctrl;

  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset, save_req, restore_req;
  logic [31:0]   sp_base;
  logic [4:0]    cwp;
  logic          busy, done, req_err, cwp_dec, cwp_inc;
  logic [NW-1:0] wim_out;
  logic [4:0]    rf_win;
  logic [3:0]    rf_idx;
  logic          rf_rd_en, rf_wr_en;
  logic [31:0]   rf_rd_data, rf_wr_data;
  logic          mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [15:0]   spill_cnt, fill_cnt;

  int n_cmp = 0, n_fail = 0;
  int n_store = 0, n_load = 0, n_dec = 0, n_inc = 0;
  int stall_n = 0, stall_cnt = 0;
  logic [63:0] st_q[$];
  logic [31:0] ld_q[$];

  // Register file contents are kept XORed with a per-slot pattern so an all-zero
  // array still reads back distinct, recognisable values.
  logic [31:0] rf_mem [32][16] = '{default: '0};

  window_spill_fill_ctrl #(.NWINDOWS(NW), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req),
    .sp_base(sp_base), .cwp(cwp), .busy(busy), .done(done), .req_err(req_err),
    .cwp_dec(cwp_dec), .cwp_inc(cwp_inc), .wim_out(wim_out), .rf_win(rf_win),
    .rf_idx(rf_idx), .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .spill_cnt(spill_cnt), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [4:0] w, input logic [3:0] k);
    return 32'h5A00_0000 | (32'(w) << 8) | 32'(k);
  endfunction

  function automatic logic [31:0] rfval(input logic [4:0] w, input logic [3:0] k);
    return rf_mem[w][k] ^ pat(w, k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rfval(rf_win, rf_idx);
    if (rf_wr_en) rf_mem[rf_win][rf_idx] <= rf_wr_data ^ pat(rf_win, rf_idx);
  end

  assign mem_ready = mem_req && (stall_cnt >= stall_n);

  always @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= 0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= mem_req && mem_ready && !mem_we;
      mem_rdata  <= 32'hA0 + {28'd0, mem_addr[5:2]};
      stall_cnt  <= (mem_req && !mem_ready) ? stall_cnt + 1 : 0;
    end
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      check("onehot", 64'($countones({cwp_inc, cwp_dec, rf_wr_en, rf_rd_en, mem_req}) <= 1), 64'd1);
      if (prev_stall && mem_req) begin
        check("stall_addr", 64'(mem_addr), 64'(prev_addr));
        check("stall_wdata", 64'(mem_wdata), 64'(prev_wdata));
      end
      prev_stall <= mem_req && !mem_ready;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
      if (cwp_dec) n_dec++;
      if (cwp_inc) n_inc++;
      if (mem_req && mem_ready && mem_we) begin
        n_store++;
        if (st_q.size() == 0) check("store_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          logic [63:0] e;
          e = st_q.pop_front();
          check("store_addr", 64'(mem_addr), 64'(e[63:32]));
          check("store_data", 64'(mem_wdata), 64'(e[31:0]));
        end
      end
      if (mem_req && mem_ready && !mem_we) begin
        n_load++;
        if (ld_q.size() == 0) check("load_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("load_addr", 64'(mem_addr), 64'(ld_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Request is presented for one cycle t; returns at the negedge inside t+1.
  task automatic pulse_req(input logic s, input logic r, input logic [4:0] c, input logic [31:0] base);
    @(negedge clk);
    cwp = c; sp_base = base; save_req = s; restore_req = r;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_spill(input logic [4:0] c, input logic [31:0] base, input int stall,
                          input int lat, input logic [NW-1:0] exp_wim);
    logic [4:0] w;
    int cyc;
    w = (c == 0) ? 5'(NW - 1) : c - 5'd1;
    for (int k = 0; k < 16; k++)
      st_q.push_back({base + 32'(4 * k), rfval(w, 4'(k))});
    stall_n = stall;
    pulse_req(1'b1, 1'b0, c, base);
    wait_done(cyc);
    check("spill_latency", 64'(cyc), 64'(lat));
    check("spill_cwp_dec", 64'(cwp_dec), 64'd1);
    check("spill_cwp_inc", 64'(cwp_inc), 64'd0);
    @(negedge clk);
    check("spill_wim", 64'(wim_out), 64'(exp_wim));
    check("spill_idle", 64'(busy), 64'd0);
    check("spill_q_empty", 64'(st_q.size()), 64'd0);
    stall_n = 0;
  endtask

  initial begin
    int cyc, d0, s0;
    reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; sp_base = '0; cwp = 5'd1;
    do_reset();
    check("rst_wim", 64'(wim_out), 64'h04);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_spill_cnt", 64'(spill_cnt), 64'd0);
    check("rst_fill_cnt", 64'(fill_cnt), 64'd0);

    // No-trap SAVE from CWP 1
    pulse_req(1'b1, 1'b0, 5'd1, 32'h0);
    check("notrap_done", 64'(done), 64'd1);
    check("notrap_cwp_dec", 64'(cwp_dec), 64'd1);
    check("notrap_busy", 64'(busy), 64'd0);
    check("notrap_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("notrap_done_low", 64'(done), 64'd0);
    check("notrap_wim", 64'(wim_out), 64'h04);

    // Spill window 2
    do_spill(5'd3, 32'h1000, 0, 33, 8'h02);
    check("spill_cnt1", 64'(spill_cnt), 64'd1);

    // Fill window 2 from a fresh reset
    do_reset();
    for (int k = 0; k < 16; k++) ld_q.push_back(32'h2000 + 32'(4 * k));
    pulse_req(1'b0, 1'b1, 5'd1, 32'h2000);
    wait_done(cyc);
    check("fill_latency", 64'(cyc), 64'd49);
    check("fill_cwp_inc", 64'(cwp_inc), 64'd1);
    @(negedge clk);
    check("fill_wim", 64'(wim_out), 64'h08);
    check("fill_cnt1", 64'(fill_cnt), 64'd1);
    check("fill_q_empty", 64'(ld_q.size()), 64'd0);
    for (int k = 0; k < 16; k++)
      check("fill_rf", 64'(rfval(5'd2, 4'(k))), 64'(32'hA0 + 32'(k)));

    // Spill window 3 with three wait cycles per store
    do_spill(5'd4, 32'h1800, 3, 81, 8'h04);
    check("stall_spill_cnt", 64'(spill_cnt), 64'd1);

    // Conflicting requests
    d0 = n_dec;
    pulse_req(1'b1, 1'b1, 5'd1, 32'h0);
    check("err_pulse", 64'(req_err), 64'd1);
    check("err_done", 64'(done), 64'd0);
    check("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("err_pulse_low", 64'(req_err), 64'd0);
    check("err_wim", 64'(wim_out), 64'h04);
    check("err_mem_req", 64'(mem_req), 64'd0);
    check("err_no_cwp", 64'(n_dec), 64'(d0));

    // Walk WIM down to bit 7, then wrap from CWP 0
    do_spill(5'd3, 32'h4000, 0, 33, 8'h02);
    do_spill(5'd2, 32'h4100, 0, 33, 8'h01);
    do_spill(5'd1, 32'h4200, 0, 33, 8'h80);
    do_spill(5'd0, 32'h4300, 0, 33, 8'h40);
    check("wrap_spill_cnt", 64'(spill_cnt), 64'd5);

    // Abort a spill of window 6 after five stores
    for (int k = 0; k < 5; k++)
      st_q.push_back({32'h3000 + 32'(4 * k), rfval(5'd6, 4'(k))});
    s0 = n_store;
    pulse_req(1'b1, 1'b0, 5'd7, 32'h3000);
    cyc = 0;
    while (n_store < s0 + 5 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("abort_stores", 64'(n_store), 64'(s0 + 5));
    d0 = n_dec;
    do_reset();
    check("abort_wim", 64'(wim_out), 64'h04);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_q_empty", 64'(st_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_cwp", 64'(n_dec), 64'(d0));
    check("abort_mem_req", 64'(mem_req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
